// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin arbiter sequencing writes from N_REQ requesters into one shared register
module dff_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  input  logic                       clr,
  output logic [N_REQ-1:0]           grant,
  output logic [N_REQ-1:0]           ack,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid
);
  localparam int OW = $clog2(N_REQ);
  localparam logic [OW:0] NR = (OW+1)'(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;
  state_t state, state_n;
  logic [OW-1:0] ptr, ptr_n, owner_n, winner;
  logic [OW:0] idx;
  logic [N_REQ-1:0] grant_n, ack_n;
  logic [WIDTH-1:0] q_n;
  logic q_valid_n;
  assign busy = state != IDLE;
  // scan downward in offset so the requester closest to ptr is the last (winning) assignment
  always_comb begin
    winner = ptr;
    idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (OW+1)'(k);
      idx = idx >= NR ? idx - NR : idx;
      if (req[idx[OW-1:0]]) winner = idx[OW-1:0];
    end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    owner_n = owner;
    grant_n = grant;
    ack_n = '0;
    q_n = q;
    q_valid_n = q_valid;
    case (state)
      IDLE: if (|req) begin
        grant_n = ONE << winner;
        owner_n = winner;
        state_n = WRITE;
      end
      WRITE: begin
        q_n = wdata[owner*WIDTH +: WIDTH];
        q_valid_n = 1'b1;
        ack_n = ONE << owner;
        state_n = RELEASE;
      end
      RELEASE: if (!req[owner]) begin
        grant_n = '0;
        ptr_n = owner == OW'(N_REQ-1) ? '0 : owner + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (clr) begin
      q_n = '0;
      q_valid_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      grant <= '0;
      ack <= '0;
      q <= '0;
      q_valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
      grant <= grant_n;
      ack <= ack_n;
      q <= q_n;
      q_valid <= q_valid_n;
    end
  end
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed and randomized transactions checked against a transaction-level round-robin model
module tb_dff_bank_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0, reset = 1'b1, clr = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0] grant, ack;
  logic [1:0] owner;
  logic busy, q_valid;
  logic [W-1:0] q;
  int checks = 0, errors = 0, mptr = 0;
  logic [W-1:0] data [N];
  logic [W-1:0] exp_q = '0;
  logic exp_qv = 1'b0;

  dff_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .clr(clr),
    .grant(grant), .ack(ack), .owner(owner), .busy(busy), .q(q), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load();
    for (int i = 0; i < N; i++) wdata[i*W +: W] = data[i];
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_q"}, q, 0);
    chk({tag, "_q_valid"}, q_valid, 0);
  endtask

  // first pending requester at or after the model pointer, wrapping
  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(mptr + k) % N]) return (mptr + k) % N;
    return -1;
  endfunction

  task automatic txn(input logic [N-1:0] r, input int hold, input bit cw, input logic [N-1:0] add);
    int w;
    w = pick(r);
    req = r;
    load();
    step();
    chk("grant", grant, 1 << w);
    chk("owner", owner, w);
    chk("busy", busy, 1);
    chk("ack_early", ack, 0);
    clr = cw;
    step();
    clr = 1'b0;
    exp_q = cw ? '0 : data[w];
    exp_qv = !cw;
    chk("ack", ack, 1 << w);
    chk("q", q, exp_q);
    chk("q_valid", q_valid, exp_qv);
    for (int h = 0; h < hold; h++) begin
      req = req | add;
      step();
      chk("hold_grant", grant, 1 << w);
      chk("hold_ack", ack, 0);
      chk("hold_busy", busy, 1);
    end
    req[w] = 1'b0;
    step();
    chk("release_grant", grant, 0);
    chk("release_busy", busy, 0);
    chk("release_ack", ack, 0);
    chk("q_keep", q, exp_q);
    chk("q_valid_keep", q_valid, exp_qv);
    mptr = (w + 1) % N;
  endtask

  initial begin
    for (int i = 0; i < N; i++) data[i] = W'($urandom);
    step();
    chk_zero("reset");
    reset = 1'b0;
    data[1] = 8'hA5;
    txn(4'b0010, 0, 1'b0, '0);
    reset = 1'b1;
    step();
    chk_zero("reset2");
    reset = 1'b0;
    mptr = 0;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < N; i++) data[i] = W'($urandom);
      chk("rr_order", pick(4'b1111), t % N);
      txn(4'b1111, 0, 1'b0, '0);
    end
    txn(4'b0100, 0, 1'b0, '0);
    chk("wrap_first", pick(4'b0101), 0);
    txn(4'b0101, 0, 1'b0, '0);
    chk("wrap_second", pick(4'b0101), 2);
    txn(4'b0101, 0, 1'b0, '0);
    data[1] = W'($urandom);
    txn(4'b0010, 5, 1'b0, 4'b0001);
    txn(4'b0001, 0, 1'b0, '0);
    data[3] = 8'h3C;
    txn(4'b1000, 0, 1'b1, '0);
    data[2] = 8'h5A;
    load();
    req = 4'b0100;
    step();
    step();
    chk("pre_reset_ack", ack, 4'b0100);
    step();
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1 chk_zero("async_reset");
    req = '0;
    #2 reset = 1'b0;
    mptr = 0;
    exp_q = '0;
    exp_qv = 1'b0;
    txn(4'b1000, 0, 1'b0, '0);
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) data[i] = W'($urandom);
      txn(N'($urandom_range(1, 15)), $urandom_range(0, 2), $urandom_range(0, 7) == 0, '0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter and write sequencer that shares one WIDTH-bit holding register among N_REQ requesters. Each requester raises a request with its write data. The block grants one requester at a time, loads that requester's data into the register, and returns a one-cycle acknowledge. It sits between the requesting control FSMs and the shared storage flop, and it is the only writer of that flop.

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- WIDTH, default 8: data width of the shared register.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request level.
- wdata  input  N_REQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH].
- clr  input  1  synchronous clear of the shared register, active-high.
- grant  output  N_REQ  one-hot grant, registered.
- ack  output  N_REQ  one-hot, one-cycle write-done pulse, registered.
- owner  output  clog2(N_REQ)  index of the current or last granted requester.
- busy  output  1  high whenever state is not IDLE.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  high once q holds written data; low after reset or clr.

## Operation
- FSM states: IDLE, WRITE, RELEASE.
- IDLE: if any req bit is high, pick the winner by scanning from ptr upward with modulo N_REQ wrap. Then grant <= onehot(winner), owner <= winner, and go to WRITE. If no req bit is high, stay in IDLE.
- WRITE: q <= wdata slice of owner, q_valid <= 1, ack <= onehot(owner), go to RELEASE.
  - The write completes even if req[owner] dropped during WRITE.
- RELEASE: ack <= 0. If req[owner] == 0, then grant <= 0, ptr <= (owner+1) mod N_REQ, and go to IDLE. Otherwise hold the grant and stay in RELEASE.
- Requester contract: hold req and wdata stable from assertion until ack is seen, then deassert req.
- clr:
  - In any state, q <= 0 and q_valid <= 0.
  - If clr and a WRITE load fall on the same edge, clr wins. ack still pulses and the FSM advances normally.
- Reset values: state=IDLE, ptr=0, grant=0, ack=0, owner=0, busy=0, q=0, q_valid=0.
- Reset mid-transaction aborts it. No ack is issued, and q returns to 0.
- Requests arriving while busy are not lost. They are sampled at the next IDLE cycle.
- At most one grant bit and one ack bit are ever high.

## Timing
- E0 (IDLE, req sampled high): grant is visible in cycle 1.
- E1: q, q_valid and ack are visible in cycle 2.
- E2: if req was dropped in cycle 2 (a combinational response to ack), grant clears in cycle 3 and the FSM is back in IDLE.
- Minimum transaction is 3 cycles. With several requesters continuously pending, the next grant appears at E3 (cycle 4). The sustained rate is one write per 3 cycles.
- Fairness: with all N_REQ requesting continuously, each requester is granted exactly once per N_REQ transactions.
- There is no timeout. A requester that never drops req holds the resource indefinitely.

## Test plan
- Single request: after reset, req=4'b0010 with wdata[15:8]=8'hA5.
  - Required: grant=0010 in cycle 1, q=8'hA5 with q_valid=1 and ack=0010 in cycle 2, grant=0 in cycle 3 once req drops.
- Round-robin: req=4'b1111 held continuously, each requester dropping req on its own ack and re-raising it the next cycle.
  - Required grant order: 0,1,2,3,0, each grant 3 cycles apart. q follows each winner's data.
- Pointer wrap and skip: ptr=3 after a grant to 2; req=4'b0101.
  - Required: grant goes to 0 next, then 2.
- Held request: requester 1 keeps req high for 5 cycles after ack.
  - Required: grant stays 0010, busy=1, and no second ack. A competing req=4'b0001 is granted only after release.
- clr collision: assert clr in the WRITE cycle of a grant carrying wdata=8'h3C.
  - Required: q=0 and q_valid=0, and ack still pulses once.
- Async reset mid-operation: assert reset during RELEASE, asynchronously.
  - Required: all outputs go to 0 immediately without waiting for a clock edge.
  - After release, the first req=4'b1000 is granted via the scan from ptr=0.
